// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns single register read/write requests into the command
// sequence of a byte-level I2C master (START / WR / RD / STOP / RESTART).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; also the cycle that re-arms req_ready
// ST_ISSUE | step pending, waiting for m_ready before strobing it
// ST_BLANK | strobe cycle; m_ready is ignored while the master reacts
// ST_WAIT  | master working; sample ack/data, advance when m_ready=1
module i2c_reg_seq #(
  parameter bit ABORT_ON_NACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic [2:0] m_cmd,
  output logic [7:0] m_din,
  output logic       m_wr_i2c,
  input  logic       m_ready,
  input  logic       m_done_tick,
  input  logic       m_ack,
  input  logic [7:0] m_dout
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BLANK, ST_WAIT} state_t;

  // One entry per bus step; the write path skips SP_RESTART..SP_RD.
  typedef enum logic [2:0] {
    SP_START, SP_WDEV, SP_WREG, SP_WDATA, SP_RESTART, SP_WDEVR, SP_RD, SP_STOP
  } step_t;

  state_t     state_q;
  step_t      step_q;
  step_t      step_nxt;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       nack_q;
  logic       step_is_wr;
  logic       byte_nack;
  logic       nack_now;

  function automatic logic [2:0] cmd_of(input step_t s);
    case (s)
      SP_START:   cmd_of = CMD_START;
      SP_RESTART: cmd_of = CMD_RESTART;
      SP_RD:      cmd_of = CMD_RD;
      SP_STOP:    cmd_of = CMD_STOP;
      default:    cmd_of = CMD_WR;
    endcase
  endfunction

  // Address bytes carry the R/W bit in the LSB; RD's din of 8'h01 tells the
  // master to NACK the single byte it reads.
  function automatic logic [7:0] din_of(input step_t s, input logic [6:0] dev,
                                        input logic [7:0] rg, input logic [7:0] wd);
    case (s)
      SP_WDEV:  din_of = {dev, 1'b0};
      SP_WREG:  din_of = rg;
      SP_WDATA: din_of = wd;
      SP_WDEVR: din_of = {dev, 1'b1};
      SP_RD:    din_of = 8'h01;
      default:  din_of = 8'h00;
    endcase
  endfunction

  // NACK seen this cycle is folded in so an ack and m_ready arriving together
  // still steer the abort decision.
  always_comb begin
    step_is_wr = (step_q == SP_WDEV) || (step_q == SP_WREG) ||
                 (step_q == SP_WDATA) || (step_q == SP_WDEVR);
    byte_nack  = (state_q == ST_WAIT) && m_done_tick && step_is_wr && m_ack;
    nack_now   = nack_q | byte_nack;
  end

  // Step successor, with the abort shortcut to STOP after a NACKed write byte.
  always_comb begin
    step_nxt = SP_STOP;
    case (step_q)
      SP_START:   step_nxt = SP_WDEV;
      SP_WDEV:    step_nxt = SP_WREG;
      SP_WREG:    step_nxt = rw_q ? SP_RESTART : SP_WDATA;
      SP_WDATA:   step_nxt = SP_STOP;
      SP_RESTART: step_nxt = SP_WDEVR;
      SP_WDEVR:   step_nxt = SP_RD;
      SP_RD:      step_nxt = SP_STOP;
      default:    step_nxt = SP_STOP;
    endcase
    if (ABORT_ON_NACK && step_is_wr && nack_now) step_nxt = SP_STOP;
  end

  assign busy = ~req_ready;

  // Sequencer FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= SP_START;
      rw_q      <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      m_wr_i2c  <= 1'b0;
      m_cmd     <= CMD_START;
      m_din     <= 8'h00;
    end else begin
      m_wr_i2c  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            rw_q      <= req_rw;
            dev_q     <= req_dev;
            reg_q     <= req_reg;
            wdata_q   <= req_wdata;
            nack_q    <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
            req_ready <= 1'b0;
            step_q    <= SP_START;
            if (m_ready) begin
              m_wr_i2c <= 1'b1;
              m_cmd    <= CMD_START;
              m_din    <= 8'h00;
              state_q  <= ST_BLANK;
            end else begin
              state_q  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (m_ready) begin
            m_wr_i2c <= 1'b1;
            m_cmd    <= cmd_of(step_q);
            m_din    <= din_of(step_q, dev_q, reg_q, wdata_q);
            state_q  <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          nack_q <= nack_now;
          if (m_done_tick && (step_q == SP_RD)) rsp_rdata <= m_dout;
          if (m_ready) begin
            if (step_q == SP_STOP) begin
              rsp_valid <= 1'b1;
              rsp_nack  <= nack_now;
              state_q   <= ST_IDLE;
            end else begin
              step_q   <= step_nxt;
              m_wr_i2c <= 1'b1;
              m_cmd    <= cmd_of(step_nxt);
              m_din    <= din_of(step_nxt, dev_q, reg_q, wdata_q);
              state_q  <= ST_BLANK;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed bench with a behavioural byte-level I2C master.
// Two DUT copies (abort on / abort off) share stimulus; sel picks which one
// receives requests and drives the observed outputs.
module tb_i2c_reg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;
  logic       sel;

  logic       rr_a, rv_a, rn_a, bz_a, wr_a;
  logic [7:0] rd_a, din_a;
  logic [2:0] cmd_a;
  logic       rr_b, rv_b, rn_b, bz_b, wr_b;
  logic [7:0] rd_b, din_b;
  logic [2:0] cmd_b;

  logic       o_req_ready, o_rsp_valid, o_rsp_nack, o_busy, o_wr;
  logic [7:0] o_rsp_rdata, o_din;
  logic [2:0] o_cmd;

  i2c_reg_seq #(.ABORT_ON_NACK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr_a),
    .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_nack(rn_a), .busy(bz_a),
    .m_cmd(cmd_a), .m_din(din_a), .m_wr_i2c(wr_a), .m_ready(m_ready),
    .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout));

  i2c_reg_seq #(.ABORT_ON_NACK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr_b),
    .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_nack(rn_b), .busy(bz_b),
    .m_cmd(cmd_b), .m_din(din_b), .m_wr_i2c(wr_b), .m_ready(m_ready),
    .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout));

  assign o_req_ready = sel ? rr_b  : rr_a;
  assign o_rsp_valid = sel ? rv_b  : rv_a;
  assign o_rsp_rdata = sel ? rd_b  : rd_a;
  assign o_rsp_nack  = sel ? rn_b  : rn_a;
  assign o_busy      = sel ? bz_b  : bz_a;
  assign o_wr        = sel ? wr_b  : wr_a;
  assign o_cmd       = sel ? cmd_b : cmd_a;
  assign o_din       = sel ? din_b : din_a;

  always #5 clk = ~clk;

  // master model knobs (written by the stimulus process only)
  int         txn_id     = 0;
  int         nack_idx   = -1;
  int         extra_hold = 0;
  bit         stray      = 1'b0;
  logic [7:0] rbyte      = 8'h00;

  // master model state (written by the master process only)
  int         seen_id  = 0;
  int         n_log    = 0;
  int         viol     = 0;
  int         cnt      = 0;
  bit         cur_byte = 1'b0;
  bit         cur_nack = 1'b0;
  logic       prev_wr  = 1'b0;
  logic [2:0] last_cmd = 3'd0;
  logic [7:0] last_din = 8'h00;
  logic [2:0] log_cmd [16];
  logic [7:0] log_din [16];

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] exp_seq [7];

  // Behavioural master: logs strobes, counts protocol violations, answers
  // each byte with a done tick after a few busy cycles.
  initial begin
    m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (seen_id != txn_id) begin
        seen_id = txn_id;
        n_log   = 0;
        viol    = 0;
      end
      if (rst) begin
        m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0;
        cnt = 0; prev_wr = 1'b0; last_cmd = 3'd0; last_din = 8'h00;
      end else begin
        if (o_wr) begin
          if (!m_ready || prev_wr) viol++;
          if (n_log < 16) begin
            log_cmd[n_log] = o_cmd;
            log_din[n_log] = o_din;
          end
          cur_byte = (o_cmd == 3'd1) || (o_cmd == 3'd2) || (stray && o_cmd == 3'd0);
          cur_nack = (o_cmd == 3'd1) && (n_log == nack_idx);
          n_log++;
          m_ready = 1'b0;
          cnt = 4 + ((o_cmd == 3'd0) ? extra_hold : 0);
          last_cmd = o_cmd;
          last_din = o_din;
        end else begin
          if (o_cmd !== last_cmd || o_din !== last_din) viol++;
          if (!m_ready) begin
            if (cnt > 1) cnt--;
            else if (cnt == 1) begin
              cnt = 0;
              if (cur_byte) begin
                m_done_tick = 1'b1;
                m_ack = (o_cmd == 3'd0) ? 1'b1 : cur_nack;
                m_dout = rbyte;
              end else begin
                m_ready = 1'b1;
              end
            end else begin
              m_done_tick = 1'b0;
              m_ack = 1'b0;
              m_ready = 1'b1;
            end
          end
        end
        prev_wr = o_wr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // exp_seq entry: {din_checked, cmd[2:0], din[7:0]}
  task automatic check_seq(input string name, input int n);
    logic [11:0] got;
    check({name, "_n_strobes"}, n_log, n);
    check({name, "_master_viol"}, viol, 0);
    for (int i = 0; i < n && i < n_log; i++) begin
      got = {exp_seq[i][11], log_cmd[i], exp_seq[i][11] ? log_din[i] : 8'h00};
      check($sformatf("%s_strobe%0d", name, i), got, exp_seq[i]);
    end
  endtask

  // Called just after a negedge; returns just after the negedge that follows
  // the response pulse.
  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input bit noise,
                         output logic got_nack, output logic [7:0] got_rdata);
    bit got;
    txn_id++;
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = noise; req_rw = ~rw; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
    got = 1'b0; got_nack = 1'b0; got_rdata = 8'h00;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (i == 0) check("start_latency", {o_wr, o_cmd}, 4'b1000);
      if (o_rsp_valid) begin
        got = 1'b1;
        got_nack = o_rsp_nack;
        got_rdata = o_rsp_rdata;
        check("ready_low_at_rsp", o_req_ready, 1'b0);
      end
    end
    req_valid = 1'b0;
    check("rsp_seen", got, 1'b1);
    @(negedge clk);
    check("ready_after_rsp", o_req_ready, 1'b1);
    check("rsp_one_cycle", o_rsp_valid, 1'b0);
    check("busy_after_rsp", o_busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       nk;
    logic [7:0] rd;
    sel = 1'b0; rst = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5;

    // reset dominates a simultaneous request
    repeat (3) @(negedge clk);
    check("rst_req_ready", o_req_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_rdata", o_rsp_rdata, 8'h00);
    check("rst_rsp_nack", o_rsp_nack, 1'b0);
    check("rst_wr", o_wr, 1'b0);
    check("rst_cmd", o_cmd, 3'b000);
    check("rst_din", o_din, 8'h00);
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_no_strobe", o_wr, 1'b0);

    // plain write, all ACK
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    check("wr_nack", nk, 1'b0);
    check("wr_rdata", rd, 8'h00);
    exp_seq = '{12'h000, 12'h9A0, 12'h910, 12'h9A5, 12'h300, 12'h000, 12'h000};
    check_seq("wr", 5);

    // read with requests hammering while busy (must not queue)
    rbyte = 8'h3C;
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 1'b1, nk, rd);
    check("rd_nack", nk, 1'b0);
    check("rd_rdata", rd, 8'h3C);
    exp_seq = '{12'h000, 12'h9A0, 12'h922, 12'h400, 12'h9A1, 12'hA01, 12'h300};
    check_seq("rd", 7);
    repeat (5) @(negedge clk);
    check("no_queued_req", n_log, 7);
    check("idle_ready", o_req_ready, 1'b1);

    // back-to-back pair; the second sees a stray done tick on START
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    stray = 1'b1;
    run_txn(1'b0, 7'h12, 8'h34, 8'h56, 1'b0, nk, rd);
    stray = 1'b0;
    check("stray_nack", nk, 1'b0);
    exp_seq = '{12'h000, 12'h924, 12'h934, 12'h956, 12'h300, 12'h000, 12'h000};
    check_seq("b2b", 5);

    // NACK on address byte, abort enabled
    nack_idx = 1;
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    check("abort_nack", nk, 1'b1);
    check("abort_rdata", rd, 8'h00);
    exp_seq = '{12'h000, 12'h9A0, 12'h300, 12'h000, 12'h000, 12'h000, 12'h000};
    check_seq("abort", 3);

    // read NACKed on register byte, abort enabled: RD never issued
    nack_idx = 2;
    run_txn(1'b1, 7'h50, 8'h22, 8'h00, 1'b0, nk, rd);
    check("rd_abort_nack", nk, 1'b1);
    check("rd_abort_rdata", rd, 8'h00);
    exp_seq = '{12'h000, 12'h9A0, 12'h922, 12'h300, 12'h000, 12'h000, 12'h000};
    check_seq("rd_abort", 4);

    // NACK on address byte, abort disabled
    sel = 1'b1; nack_idx = 1;
    @(negedge clk);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    check("noabort_nack", nk, 1'b1);
    exp_seq = '{12'h000, 12'h9A0, 12'h910, 12'h9A5, 12'h300, 12'h000, 12'h000};
    check_seq("noabort", 5);

    // master holds off for 20 extra cycles after START
    sel = 1'b0; nack_idx = -1; extra_hold = 20;
    @(negedge clk);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    extra_hold = 0;
    check("hold_nack", nk, 1'b0);
    check_seq("hold", 5);

    // reset during the RD wait, then a fresh write
    sel = 1'b1; nack_idx = 1; rbyte = 8'h77;
    @(negedge clk);
    txn_id++;
    req_valid = 1'b1; req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h22; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 400 && n_log < 6; i++) @(negedge clk);
    check("reach_rd", n_log, 6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", o_req_ready, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
    check("mid_rst_rsp_rdata", o_rsp_rdata, 8'h00);
    check("mid_rst_rsp_nack", o_rsp_nack, 1'b0);
    check("mid_rst_wr", o_wr, 1'b0);
    check("mid_rst_cmd", o_cmd, 3'b000);
    check("mid_rst_din", o_din, 8'h00);
    rst = 1'b0; nack_idx = -1;
    repeat (4) @(negedge clk);
    check("no_stop_after_rst", n_log, 6);
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, nk, rd);
    check("post_rst_nack", nk, 1'b0);
    check("post_rst_rdata", rd, 8'h00);
    exp_seq = '{12'h000, 12'h9A0, 12'h910, 12'h9A5, 12'h300, 12'h000, 12'h000};
    check_seq("post_rst", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
